// File: rtl/vlsu_cam_prio.sv
// Multi-port CAM with per-entry valid bits, head-relative priority selection
// and multi-hit reporting. Every search result is registered (one-cycle latency).
module vlsu_cam_prio #(
    parameter int WIDTH       = 50,
    parameter int DEPTH       = 32,
    parameter int WRITE_PORTS = 1,
    parameter int READ_PORTS  = 3,
    parameter int PRIO_MODE   = 1,
    parameter int ADDRESS     = $clog2(DEPTH)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [ADDRESS-1:0]                       head_i,
    input  logic [READ_PORTS-1:0][DEPTH-1:0]         enable_i,
    input  logic [WRITE_PORTS-1:0]                   write_i,
    input  logic [WRITE_PORTS-1:0][ADDRESS-1:0]      write_addr_i,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]        write_data_i,
    input  logic                                     clear_i,
    input  logic [ADDRESS-1:0]                       clear_addr_i,
    input  logic                                     flush_i,
    input  logic [READ_PORTS-1:0]                    read_i,
    input  logic [READ_PORTS-1:0][WIDTH-1:0]         read_data_i,
    output logic [READ_PORTS-1:0]                    match_o,
    output logic [READ_PORTS-1:0][ADDRESS-1:0]       match_data_o,
    output logic [READ_PORTS-1:0]                    multi_o,
    output logic [DEPTH-1:0]                         valid_o
);

    logic [WIDTH-1:0]                    data_q [DEPTH];
    logic [DEPTH-1:0]                    valid_q, valid_d;
    logic [READ_PORTS-1:0][DEPTH-1:0]    hit;
    logic [READ_PORTS-1:0]               match_q, match_d;
    logic [READ_PORTS-1:0]               multi_q, multi_d;
    logic [READ_PORTS-1:0][ADDRESS-1:0]  match_data_q, match_data_d;

    // Entry visited at scan position k; wraps naturally at ADDRESS bits.
    function automatic logic [ADDRESS-1:0] scan_idx(input logic [ADDRESS-1:0] head,
                                                    input logic [ADDRESS-1:0] k);
        logic [ADDRESS-1:0] idx;
        if (PRIO_MODE == 1) begin
            idx = head + k;
        end else if (PRIO_MODE == 2) begin
            idx = head - ADDRESS'(1) - k;
        end else begin
            idx = k;
        end
        return idx;
    endfunction

    // Searches see only pre-edge contents and valid bits.
    always_comb begin
        hit = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            for (int e = 0; e < DEPTH; e++) begin
                hit[r][e] = read_i[r] & enable_i[r][e] & valid_q[e] &
                            (data_q[e] == read_data_i[r]);
            end
        end
    end

    always_comb begin
        match_d      = '0;
        multi_d      = '0;
        match_data_d = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            match_d[r] = |hit[r];
            multi_d[r] = |(hit[r] & (hit[r] - DEPTH'(1)));
            // Scan from the far end so the earliest scan position is the last to win.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hit[r][scan_idx(head_i, ADDRESS'(k))]) begin
                    match_data_d[r] = scan_idx(head_i, ADDRESS'(k));
                end
            end
        end
    end

    // Writes are applied last so they beat both clear and flush.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (clear_i) begin
            valid_d[clear_addr_i] = 1'b0;
        end
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (write_i[p]) begin
                valid_d[write_addr_i[p]] = 1'b1;
            end
        end
    end

    // Ascending port loop: the highest-numbered port's assignment lands last.
    always_ff @(posedge clk) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (write_i[p]) begin
                data_q[write_addr_i[p]] <= write_data_i[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            match_q      <= '0;
            multi_q      <= '0;
            match_data_q <= '0;
        end else begin
            valid_q      <= valid_d;
            match_q      <= match_d;
            multi_q      <= multi_d;
            match_data_q <= match_data_d;
        end
    end

    assign match_o      = match_q;
    assign multi_o      = multi_q;
    assign match_data_o = match_data_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_vlsu_cam_prio.sv
// Directed bench for vlsu_cam_prio: one instance per priority mode, all driven
// by the same stimulus and checked against hand-computed values.
module tb_vlsu_cam_prio;

    localparam int W = 50;
    localparam int D = 32;
    localparam int A = 5;
    localparam int R = 3;

    logic                clk;
    logic                rst;
    logic [A-1:0]        head;
    logic [R-1:0][D-1:0] enable;
    logic [0:0]          wr;
    logic [0:0][A-1:0]   waddr;
    logic [0:0][W-1:0]   wdata;
    logic                clear;
    logic [A-1:0]        clear_addr;
    logic                flush;
    logic [R-1:0]        rd;
    logic [R-1:0][W-1:0] rdata;

    logic [R-1:0]        mt0, mt1, mt2;
    logic [R-1:0][A-1:0] md0, md1, md2;
    logic [R-1:0]        mu0, mu1, mu2;
    logic [D-1:0]        v0, v1, v2;

    int ncmp = 0;
    int nerr = 0;

    vlsu_cam_prio #(.WIDTH(W), .DEPTH(D), .WRITE_PORTS(1), .READ_PORTS(R), .PRIO_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .head_i(head), .enable_i(enable), .write_i(wr),
        .write_addr_i(waddr), .write_data_i(wdata), .clear_i(clear), .clear_addr_i(clear_addr),
        .flush_i(flush), .read_i(rd), .read_data_i(rdata), .match_o(mt0),
        .match_data_o(md0), .multi_o(mu0), .valid_o(v0));

    vlsu_cam_prio #(.WIDTH(W), .DEPTH(D), .WRITE_PORTS(1), .READ_PORTS(R), .PRIO_MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .head_i(head), .enable_i(enable), .write_i(wr),
        .write_addr_i(waddr), .write_data_i(wdata), .clear_i(clear), .clear_addr_i(clear_addr),
        .flush_i(flush), .read_i(rd), .read_data_i(rdata), .match_o(mt1),
        .match_data_o(md1), .multi_o(mu1), .valid_o(v1));

    vlsu_cam_prio #(.WIDTH(W), .DEPTH(D), .WRITE_PORTS(1), .READ_PORTS(R), .PRIO_MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .head_i(head), .enable_i(enable), .write_i(wr),
        .write_addr_i(waddr), .write_data_i(wdata), .clear_i(clear), .clear_addr_i(clear_addr),
        .flush_i(flush), .read_i(rd), .read_data_i(rdata), .match_o(mt2),
        .match_data_o(md2), .multi_o(mu2), .valid_o(v2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
        wr       = 1'b1;
        waddr[0] = a;
        wdata[0] = d;
        tick();
        wr       = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        head       = '0;
        enable     = '1;
        wr         = '0;
        waddr      = '0;
        wdata      = '0;
        clear      = 1'b0;
        clear_addr = '0;
        flush      = 1'b0;
        rd         = '0;
        rdata      = '0;
        #2;
        chk("reset_valid", 64'(v0), 64'h0);
        chk("reset_match", 64'({mt0, mt1, mt2}), 64'h0);
        chk("reset_index", 64'(md1), 64'h0);
        chk("reset_multi", 64'({mu0, mu1, mu2}), 64'h0);
        tick();
        tick();
        rst = 1'b0;

        // Fill: entry e holds e+1
        for (int e = 0; e < D; e++) do_write(A'(e), W'(e + 1));
        chk("fill_valid_m0", 64'(v0), 64'hFFFF_FFFF);
        chk("fill_valid_m1", 64'(v1), 64'hFFFF_FFFF);
        chk("fill_valid_m2", 64'(v2), 64'hFFFF_FFFF);

        rd = 3'b001; rdata[0] = 50'd5;
        tick();
        rd = 3'b000;
        chk("key5_match", 64'(mt1), 64'h1);
        chk("key5_idx_m0", 64'(md0[0]), 64'd4);
        chk("key5_idx_m1", 64'(md1[0]), 64'd4);
        chk("key5_idx_m2", 64'(md2[0]), 64'd4);
        chk("key5_multi", 64'(mu1[0]), 64'h0);

        // Read gating
        rd = 3'b001; rdata[0] = 50'd32;
        tick();
        chk("gate1_match", 64'(mt1[0]), 64'h1);
        chk("gate1_idx", 64'(md1[0]), 64'd31);
        rd = 3'b000; rdata[0] = 50'd31;
        tick();
        chk("gate0_match", 64'(mt1[0]), 64'h0);
        chk("gate0_idx", 64'(md1[0]), 64'd0);
        rd = 3'b001; rdata[0] = 50'd30;
        tick();
        rd = 3'b000;
        chk("gate2_match", 64'(mt1[0]), 64'h1);
        chk("gate2_idx", 64'(md1[0]), 64'd29);

        // Priority wrap: key 7 only in entries 3 and 28
        do_write(5'd6, 50'd100);
        do_write(5'd3, 50'd7);
        do_write(5'd28, 50'd7);
        head = 5'd30;
        rd = 3'b111; rdata[0] = 50'd7; rdata[1] = 50'd7; rdata[2] = 50'd7;
        tick();
        rd = 3'b000;
        chk("prio_m0_idx", 64'(md0[0]), 64'd3);
        chk("prio_m1_idx", 64'(md1[0]), 64'd3);
        chk("prio_m2_idx", 64'(md2[0]), 64'd28);
        chk("prio_m2_idx_p2", 64'(md2[2]), 64'd28);
        chk("prio_match_all", 64'({mt0, mt1, mt2}), 64'h1FF);
        chk("prio_multi_all", 64'({mu0, mu1, mu2}), 64'h1FF);

        // Enable masking on port 1
        enable[1][3] = 1'b0;
        rd = 3'b011;
        tick();
        rd = 3'b000;
        chk("mask_m1_idx", 64'(md1[1]), 64'd28);
        chk("mask_m0_idx", 64'(md0[1]), 64'd28);
        chk("mask_multi", 64'({mu0[1], mu1[1], mu2[1]}), 64'h0);
        chk("mask_match", 64'(mt1[1]), 64'h1);
        chk("mask_p0_multi", 64'(mu1[0]), 64'h1);

        clear = 1'b1; clear_addr = 5'd28;
        tick();
        clear = 1'b0;
        chk("clear_valid28", 64'(v1[28]), 64'h0);
        rd = 3'b011;
        tick();
        rd = 3'b000;
        chk("clear_p1_match", 64'(mt1[1]), 64'h0);
        chk("clear_p1_idx", 64'(md1[1]), 64'h0);
        chk("clear_p0_idx", 64'(md2[0]), 64'd3);
        chk("clear_p0_multi", 64'(mu2[0]), 64'h0);
        enable = '1;

        // Write vs search collision: key 9 written to entry 10 while searched
        do_write(5'd8, 50'd200);
        wr = 1'b1; waddr[0] = 5'd10; wdata[0] = 50'd9;
        rd = 3'b001; rdata[0] = 50'd9;
        tick();
        wr = 1'b0;
        chk("wrsrch_same_cycle", 64'(mt1[0]), 64'h0);
        tick();
        rd = 3'b000;
        chk("wrsrch_next_match", 64'(mt1[0]), 64'h1);
        chk("wrsrch_next_idx", 64'(md1[0]), 64'd10);

        // Clear and write same entry: write wins
        clear = 1'b1; clear_addr = 5'd12;
        tick();
        chk("clear12_alone", 64'(v1[12]), 64'h0);
        wr = 1'b1; waddr[0] = 5'd12; wdata[0] = 50'd300;
        tick();
        wr = 1'b0; clear = 1'b0;
        chk("clrwr_valid12", 64'(v1[12]), 64'h1);
        rd = 3'b001; rdata[0] = 50'd300;
        tick();
        rd = 3'b000;
        chk("clrwr_idx", 64'(md1[0]), 64'd12);

        // Flush and write same cycle: only written entry survives
        flush = 1'b1; clear = 1'b1; clear_addr = 5'd5;
        wr = 1'b1; waddr[0] = 5'd5; wdata[0] = 50'd400;
        tick();
        flush = 1'b0; clear = 1'b0; wr = 1'b0;
        chk("flush_valid_m0", 64'(v0), 64'h20);
        chk("flush_valid_m2", 64'(v2), 64'h20);
        rd = 3'b011; rdata[0] = 50'd400; rdata[1] = 50'd32;
        tick();
        rd = 3'b000;
        chk("flush_hit5", 64'(md1[0]), 64'd5);
        chk("flush_match", 64'(mt1[1:0]), 64'h1);

        // Async reset during back-to-back searches
        do_write(5'd0, 50'd500);
        do_write(5'd1, 50'd501);
        do_write(5'd2, 50'd502);
        rd = 3'b111; rdata[0] = 50'd500; rdata[1] = 50'd501; rdata[2] = 50'd502;
        tick();
        chk("pre_rst_match", 64'(mt0), 64'h7);
        chk("pre_rst_idx", 64'(md0), 64'({5'd2, 5'd1, 5'd0}));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_match", 64'({mt0, mt1, mt2}), 64'h0);
        chk("async_rst_valid", 64'({v0, v1}), 64'h0);
        chk("async_rst_idx", 64'(md0), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rd = 3'b000;
        chk("post_rst_match", 64'({mt0, mt1, mt2}), 64'h0);
        chk("post_rst_valid", 64'(v2), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
